// File: rtl/sram_mem_ctl.sv
// sram_mem_ctl: bridges the core's 32-bit single-port memory request interface to an
//   external 16-bit asynchronous SRAM. Posted writes are held in a small write buffer;
//   each word is moved as two half-word SRAM cycles with WAIT_CYCLES extra cycles each.
// Latency: a read accepted in IDLE at cycle T pulses mem_valid at T+2*WAIT_CYCLES+3.
//   A buffered write popped at P starts its SRAM cycle at P+1 and takes 2*(WAIT_CYCLES+2).
// Backpressure: writes are never stalled; a write arriving with the buffer full is
//   dropped and latches wr_overflow. Reads are accepted only in IDLE with the buffer empty.
//
// Ports:
//   clk, reset (async, active-high)
//   mem_addr/mem_mask/mem_enable/mem_cmd/mem_wdata : request from the arbiter
//   mem_data/mem_valid : read return; mem_busy : controller or write buffer active
//   wr_overflow : sticky write-drop flag
//   sram_addr, sram_dq_out/sram_dq_oe/sram_dq_in, sram_ce_n/oe_n/we_n/ub_n/lb_n : SRAM pins
//
// Build option: define SRAM_MEM_CTL_HALF_SKIP_EN to skip write halves whose two byte
//   enables are both zero (a zero mask then retires without any SRAM cycle).

module sram_mem_ctl #(
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 2,
    parameter int WBUF_DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       mem_addr,
    input  logic [3:0]        mem_mask,
    input  logic              mem_enable,
    input  logic              mem_cmd,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_data,
    output logic              mem_valid,
    output logic              mem_busy,
    output logic              wr_overflow,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [15:0]       sram_dq_in,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);

    localparam logic MEM_CMD_READ  = 1'b0;
    localparam logic MEM_CMD_WRITE = 1'b1;

    localparam int WA_W  = ADDR_W - 1;                 // word address width
    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);
    localparam logic [PTR_W:0]   FIFO_MAX = (PTR_W + 1)'(WBUF_DEPTH);

`ifdef SRAM_MEM_CTL_HALF_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE, RD_LO, RD_HI, RD_DONE, WR_LO, WR_LO_REC, WR_HI, WR_HI_REC
    } state_t;

    // Write buffer
    logic [WA_W-1:0]  wb_addr_q [WBUF_DEPTH];
    logic [WA_W-1:0]  wb_addr_d [WBUF_DEPTH];
    logic [31:0]      wb_data_q [WBUF_DEPTH];
    logic [31:0]      wb_data_d [WBUF_DEPTH];
    logic [3:0]       wb_mask_q [WBUF_DEPTH];
    logic [3:0]       wb_mask_d [WBUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    // Control and working registers
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WA_W-1:0]  wk_addr_q, wk_addr_d;
    logic [31:0]      wk_data_q, wk_data_d;
    logic [3:0]       wk_mask_q, wk_mask_d;

    // Registered outputs
    logic [31:0]       mem_data_q, mem_data_d;
    logic              mem_valid_q, mem_valid_d;
    logic              overflow_q, overflow_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [15:0]       dq_out_q, dq_out_d;
    logic              dq_oe_q, dq_oe_d;
    logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic              ub_n_q, ub_n_d, lb_n_q, lb_n_d;

    logic wr_req, fifo_full, fifo_empty, push, pop, last_phase;
    logic [3:0] head_mask;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{mem_addr[31:ADDR_W+1], mem_addr[1:0]};

    assign wr_req     = mem_enable && (mem_cmd == MEM_CMD_WRITE);
    assign fifo_full  = (count_q == FIFO_MAX);
    assign fifo_empty = (count_q == '0);
    // Fullness is judged before this cycle's pop, so a write arriving on a full buffer drops.
    assign push       = wr_req && !fifo_full;
    assign last_phase = (cnt_q == CNT_LAST);
    assign head_mask  = wb_mask_q[rd_ptr_q];

    always_comb begin
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        wb_mask_d = wb_mask_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push) begin
            wb_addr_d[wr_ptr_q] = mem_addr[ADDR_W:2];
            wb_data_d[wr_ptr_q] = mem_wdata;
            wb_mask_d[wr_ptr_q] = mem_mask;
            wr_ptr_d            = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        wk_addr_d  = wk_addr_q;
        wk_data_d  = wk_data_q;
        wk_mask_d  = wk_mask_q;
        mem_data_d = mem_data_q;
        case (state_q)
            IDLE: begin
                // Pending writes go first, which keeps reads ordered after earlier writes.
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    wk_addr_d = wb_addr_q[rd_ptr_q];
                    wk_data_d = wb_data_q[rd_ptr_q];
                    wk_mask_d = head_mask;
                    if (!SKIP_EN || head_mask[1:0] != 2'b00) state_d = WR_LO;
                    else if (head_mask[3:2] != 2'b00)        state_d = WR_HI;
                    else                                     state_d = IDLE;
                end else if (mem_enable && mem_cmd == MEM_CMD_READ) begin
                    wk_addr_d = mem_addr[ADDR_W:2];
                    state_d   = RD_LO;
                end
            end
            RD_LO: if (last_phase) begin
                mem_data_d[15:0] = sram_dq_in;
                state_d          = RD_HI;
            end
            RD_HI: if (last_phase) begin
                mem_data_d[31:16] = sram_dq_in;
                state_d           = RD_DONE;
            end
            RD_DONE:   state_d = IDLE;
            WR_LO:     if (last_phase) state_d = WR_LO_REC;
            WR_LO_REC: state_d = (!SKIP_EN || wk_mask_q[3:2] != 2'b00) ? WR_HI : IDLE;
            WR_HI:     if (last_phase) state_d = WR_HI_REC;
            WR_HI_REC: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
    end

    // Pin values are decoded from the next state so they leave the chip straight from flops.
    always_comb begin
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        dq_oe_d     = 1'b0;
        ce_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        ub_n_d      = 1'b1;
        lb_n_d      = 1'b1;
        case (state_d)
            RD_LO, RD_HI: begin
                sram_addr_d = {wk_addr_d, (state_d == RD_HI)};
                ce_n_d      = 1'b0;
                oe_n_d      = 1'b0;
                ub_n_d      = 1'b0;
                lb_n_d      = 1'b0;
            end
            WR_LO, WR_LO_REC: begin
                sram_addr_d = {wk_addr_d, 1'b0};
                dq_out_d    = wk_data_d[15:0];
                dq_oe_d     = 1'b1;
                ce_n_d      = 1'b0;
                we_n_d      = (state_d != WR_LO);
                lb_n_d      = ~wk_mask_d[0];
                ub_n_d      = ~wk_mask_d[1];
            end
            WR_HI, WR_HI_REC: begin
                sram_addr_d = {wk_addr_d, 1'b1};
                dq_out_d    = wk_data_d[31:16];
                dq_oe_d     = 1'b1;
                ce_n_d      = 1'b0;
                we_n_d      = (state_d != WR_HI);
                lb_n_d      = ~wk_mask_d[2];
                ub_n_d      = ~wk_mask_d[3];
            end
            default: ;
        endcase
        mem_valid_d = (state_d == RD_DONE);
        overflow_d  = overflow_q || (wr_req && fifo_full);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WBUF_DEPTH; i++) begin
                wb_addr_q[i] <= '0;
                wb_data_q[i] <= '0;
                wb_mask_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            wk_addr_q   <= '0;
            wk_data_q   <= '0;
            wk_mask_q   <= '0;
            mem_data_q  <= '0;
            mem_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
        end else begin
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            wb_mask_q   <= wb_mask_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wk_addr_q   <= wk_addr_d;
            wk_data_q   <= wk_data_d;
            wk_mask_q   <= wk_mask_d;
            mem_data_q  <= mem_data_d;
            mem_valid_q <= mem_valid_d;
            overflow_q  <= overflow_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            ub_n_q      <= ub_n_d;
            lb_n_q      <= lb_n_d;
        end
    end

    assign mem_data    = mem_data_q;
    assign mem_valid   = mem_valid_q;
    assign mem_busy    = (state_q != IDLE) || !fifo_empty;
    assign wr_overflow = overflow_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;
    assign sram_ub_n   = ub_n_q;
    assign sram_lb_n   = lb_n_q;

endmodule

// File: tb/tb_sram_mem_ctl.sv
// Directed bench for sram_mem_ctl with a behavioural 16-bit SRAM model.
// Build option SRAM_MEM_CTL_HALF_SKIP_EN selects the matching partial-write expectations.
module tb_sram_mem_ctl;

    localparam int ADDR_W = 18;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       mem_addr;
    logic [3:0]        mem_mask;
    logic              mem_enable;
    logic              mem_cmd;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_data;
    logic              mem_valid;
    logic              mem_busy;
    logic              wr_overflow;
    logic [ADDR_W-1:0] sram_addr;
    logic [15:0]       sram_dq_out;
    logic              sram_dq_oe;
    logic [15:0]       sram_dq_in;
    logic              sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sram_mem_ctl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(2), .WBUF_DEPTH(2)) dut (
        .clk(clk), .reset(rst),
        .mem_addr(mem_addr), .mem_mask(mem_mask), .mem_enable(mem_enable),
        .mem_cmd(mem_cmd), .mem_wdata(mem_wdata),
        .mem_data(mem_data), .mem_valid(mem_valid), .mem_busy(mem_busy),
        .wr_overflow(wr_overflow),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    // SRAM model: reloaded with a known pattern whenever reset is high.
    logic [15:0] sram [0:1023];
    logic        unused_hi_addr;
    assign unused_hi_addr = ^sram_addr[ADDR_W-1:10];

    function automatic logic [15:0] init_val(input int i);
        if (i == 8) return 16'hBEEF;
        if (i == 9) return 16'hDEAD;
        return 16'hA500 ^ 16'(i);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) sram[i] <= init_val(i);
        end else if (!sram_ce_n && !sram_we_n) begin
            if (!sram_lb_n) sram[sram_addr[9:0]][7:0]  <= sram_dq_out[7:0];
            if (!sram_ub_n) sram[sram_addr[9:0]][15:8] <= sram_dq_out[15:8];
        end
    end

    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? sram[sram_addr[9:0]] : 16'h0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, ce_lo, hi_blank, hi_bad, vcnt;
        logic [17:0] first_wr;
        logic seen_wr;

        rst = 1'b1; mem_addr = '0; mem_mask = '0; mem_enable = 1'b0;
        mem_cmd = 1'b0; mem_wdata = '0;

        // ---- Reset state
        repeat (3) @(negedge clk);
        check("rst_ce_n",  32'(sram_ce_n), 32'd1);
        check("rst_oe_n",  32'(sram_oe_n), 32'd1);
        check("rst_we_n",  32'(sram_we_n), 32'd1);
        check("rst_ub_lb", 32'({sram_ub_n, sram_lb_n}), 32'd3);
        check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_addr",  32'(sram_addr), 32'd0);
        check("rst_valid", 32'(mem_valid), 32'd0);
        check("rst_busy",  32'(mem_busy), 32'd0);
        check("rst_ovf",   32'(wr_overflow), 32'd0);
        check("rst_data",  mem_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // ---- Read word 0x10: hw 8 for 3 cycles, hw 9 for 3 cycles, valid on the 7th
        mem_enable = 1'b1; mem_cmd = 1'b0; mem_addr = 32'h10;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c <= 3) begin
                check("rd_lo_addr", 32'(sram_addr), 32'h8);
                check("rd_lo_strb", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'b00100);
            end else if (c <= 6) begin
                check("rd_hi_addr", 32'(sram_addr), 32'h9);
                check("rd_hi_strb", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'b00100);
            end
            if (c < 7) check("rd_valid_early", 32'(mem_valid), 32'd0);
        end
        check("rd_valid", 32'(mem_valid), 32'd1);
        check("rd_data",  mem_data, 32'hDEADBEEF);
        mem_enable = 1'b0;
        @(negedge clk);
        check("rd_valid_pulse", 32'(mem_valid), 32'd0);

        // ---- Partial write 0x12345678, mask 0011, addr 0x20
        mem_enable = 1'b1; mem_cmd = 1'b1; mem_addr = 32'h20;
        mem_wdata = 32'h12345678; mem_mask = 4'b0011;
        @(negedge clk);
        mem_enable = 1'b0;
        ce_lo = 0; hi_blank = 0; hi_bad = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (!sram_ce_n) ce_lo++;
            if (!sram_ce_n && !sram_we_n && sram_addr == 18'h11) begin
                if (sram_ub_n && sram_lb_n) hi_blank++;
                else hi_bad++;
            end
        end
`ifdef SRAM_MEM_CTL_HALF_SKIP_EN
        check("pw_ce_cycles", 32'(ce_lo), 32'd4);
        check("pw_hi_blank",  32'(hi_blank), 32'd0);
`else
        check("pw_ce_cycles", 32'(ce_lo), 32'd8);
        check("pw_hi_blank",  32'(hi_blank), 32'd3);
`endif
        check("pw_hi_lane",  32'(hi_bad), 32'd0);
        check("pw_lo_data",  32'(sram[16]), 32'h5678);
        check("pw_hi_data",  32'(sram[17]), 32'(init_val(17)));
        check("pw_busy",     32'(mem_busy), 32'd0);

        // ---- Write 0xCAFEF00D @0x40, read it back two cycles later
        mem_enable = 1'b1; mem_cmd = 1'b1; mem_addr = 32'h40;
        mem_wdata = 32'hCAFEF00D; mem_mask = 4'b1111;
        @(negedge clk);
        mem_enable = 1'b0;
        @(negedge clk);
        mem_enable = 1'b1; mem_cmd = 1'b0; mem_addr = 32'h40;
        k = 0;
        while (!mem_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("raw_valid",   32'(mem_valid), 32'd1);
        check("raw_latency", 32'(k), 32'd15);
        check("raw_data",    mem_data, 32'hCAFEF00D);
        mem_enable = 1'b0;
        check("raw_mem_lo",  32'(sram[32]), 32'hF00D);
        check("raw_mem_hi",  32'(sram[33]), 32'hCAFE);
        @(negedge clk);

        // ---- Overflow: three write pulses during a read, depth 2
        mem_enable = 1'b1; mem_cmd = 1'b0; mem_addr = 32'h10;
        @(negedge clk);
        mem_cmd = 1'b1; mem_mask = 4'b1111; mem_addr = 32'h60; mem_wdata = 32'h11111111;
        @(negedge clk);
        mem_addr = 32'h64; mem_wdata = 32'h22222222;
        @(negedge clk);
        mem_addr = 32'h68; mem_wdata = 32'h33333333;
        @(negedge clk);
        mem_enable = 1'b0;
        check("ovf_flag", 32'(wr_overflow), 32'd1);
        check("ovf_busy", 32'(mem_busy), 32'd1);
        k = 0;
        while (!mem_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("ovf_rd_valid", 32'(mem_valid), 32'd1);
        check("ovf_rd_data",  mem_data, 32'hDEADBEEF);
        k = 0; seen_wr = 1'b0; first_wr = '0;
        while (mem_busy && k < 60) begin
            @(negedge clk);
            if (!seen_wr && !sram_ce_n && !sram_we_n) begin
                seen_wr  = 1'b1;
                first_wr = sram_addr;
            end
            k++;
        end
        check("ovf_drained",  32'(mem_busy), 32'd0);
        check("ovf_first_wr", 32'(first_wr), 32'h30);
        check("ovf_w1_lo", 32'(sram[48]), 32'h1111);
        check("ovf_w1_hi", 32'(sram[49]), 32'h1111);
        check("ovf_w2_lo", 32'(sram[50]), 32'h2222);
        check("ovf_w2_hi", 32'(sram[51]), 32'h2222);
        check("ovf_w3_lo", 32'(sram[52]), 32'(init_val(52)));
        check("ovf_w3_hi", 32'(sram[53]), 32'(init_val(53)));
        check("ovf_sticky", 32'(wr_overflow), 32'd1);

        // ---- Reset during RD_HI
        @(negedge clk);
        mem_enable = 1'b1; mem_cmd = 1'b0; mem_addr = 32'h10;
        repeat (5) @(negedge clk);
        mem_enable = 1'b0;
        check("mr_in_rd_hi", 32'(sram_addr), 32'h9);
        check("mr_ce_active", 32'(sram_ce_n), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("mr_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'b11111);
        check("mr_dq_oe",   32'(sram_dq_oe), 32'd0);
        check("mr_ovf_clr", 32'(wr_overflow), 32'd0);
        check("mr_busy",    32'(mem_busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        vcnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (mem_valid) vcnt++;
        end
        check("mr_no_valid", 32'(vcnt), 32'd0);
        check("mr_idle",     32'(mem_busy), 32'd0);
        check("mr_ce_idle",  32'(sram_ce_n), 32'd1);

        // ---- Controller still serves reads after the reset
        mem_enable = 1'b1; mem_cmd = 1'b0; mem_addr = 32'h10;
        k = 0;
        while (!mem_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("post_rst_latency", 32'(k), 32'd7);
        check("post_rst_data",    mem_data, 32'hDEADBEEF);
        mem_enable = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_mem_ctl.md
# sram_mem_ctl

Memory-side controller that turns the core's single-port 32-bit memory request interface (the `mem_*` signals driven by the fetch/data arbiter) into timed access sequences on an external 16-bit asynchronous SRAM. It holds posted writes in a small write buffer, because the arbiter issues writes as single-cycle pulses and never waits for them. It splits each word into two half-word SRAM cycles with programmable wait states, and returns read data with a one-cycle `mem_valid` pulse. It sits between the arbiter and the board SRAM pins.

## Interface
- `ADDR_W`, 18, SRAM half-word address width.
- `WAIT_CYCLES`, 2, extra cycles per SRAM access phase (W); access phase lasts W+1 cycles.
- `WBUF_DEPTH`, 2, write-buffer entries; power of two, at least 2.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `mem_addr`  in  32  byte address; only bits [ADDR_W:2] are used.
- `mem_mask`  in  4  write byte enables; bit i enables byte i.
- `mem_enable`  in  1  request valid.
- `mem_cmd`  in  1  `MEM_CMD_READ` / `MEM_CMD_WRITE` (consts.vh).
- `mem_wdata`  in  32  write data.
- `mem_data`  out  32  read data, registered, valid while `mem_valid` is high.
- `mem_valid`  out  1  one-cycle read-complete pulse.
- `mem_busy`  out  1  FSM not IDLE or write buffer non-empty.
- `wr_overflow`  out  1  sticky flag: a write was dropped because the buffer was full.
- `sram_addr`  out  ADDR_W  half-word address.
- `sram_dq_out`  out  16, `sram_dq_oe`  out  1, `sram_dq_in`  in  16  data bus.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_ub_n`, `sram_lb_n`  out  1 each  active-low strobes.

## Operation
- **Write capture:** every cycle (any state) with `mem_enable` high and `mem_cmd`==`MEM_CMD_WRITE` pushes {word addr, wdata, mask} into the FIFO.
  - If the FIFO is full, the write is dropped and `wr_overflow` is set until reset.
  - Push and pop in the same cycle are both legal.
- **Read acceptance:** only in IDLE, only when `mem_enable` high, cmd read, and the FIFO is empty. This gives read-after-write ordering; the arbiter holds read enable until it sees `mem_valid`.
- **IDLE priority:** a non-empty FIFO beats a read. IDLE pops the FIFO head into the working registers and moves to WR_LO.
- **States:** IDLE, RD_LO, RD_HI, RD_DONE, WR_LO, WR_LO_REC, WR_HI, WR_HI_REC.
- **Reads:**
  - RD_LO: `sram_addr`={word,0}, `ce_n`=`oe_n`=`ub_n`=`lb_n`=0, for W+1 cycles; `sram_dq_in` is captured into data[15:0] on the last cycle.
  - RD_HI: same with {word,1}, captured into data[31:16].
  - RD_DONE: `mem_valid`=1 for one cycle, then IDLE. Enable is ignored in RD_DONE.
- **Writes:** WR_x asserts `ce_n`=`we_n`=0, `dq_oe`=1, drives the half's data, and sets `lb_n`/`ub_n` = ~mask bits, for W+1 cycles. WR_x_REC then holds for 1 cycle with `we_n`=1 and address/data held. After WR_HI_REC the FSM returns to IDLE.
- **Byte lanes:** the low half uses mask[1:0] and wdata[15:0]; the high half uses mask[3:2] and wdata[31:16].
- **Phase counter:** counts 0..W, saturating behaviour not needed; it is cleared on every state change.
- **Outputs:** all `sram_*` outputs come straight from flops (no combinational glitches).

## Timing
- **Read latency:** enable first high in IDLE at cycle T → `mem_valid` at T+2W+3 (T+7 for W=2).
- **Write service:** pop at cycle P → WR_LO starts P+1; a full-word write occupies 2(W+2) cycles.
- **Reset values:** all strobes 1, `dq_oe`=0, `sram_addr`=0, `mem_data`=0, `mem_valid`=0, `mem_busy`=0, `wr_overflow`=0, FIFO empty, state IDLE.
- **Reset mid-access:** strobes deassert asynchronously, the in-flight request and FIFO contents are lost, and no `mem_valid` is issued afterwards.
- **Simultaneous write pulse and read in IDLE:** the write is pushed and the read is deferred until the FIFO drains.

## Configuration
- `SRAM_MEM_CTL_HALF_SKIP_EN`
  - **Defined:** a write half whose two mask bits are both 0 skips its WR_x/WR_x_REC states. Mask 0 completes straight back to IDLE with no SRAM cycle.
  - **Undefined:** both halves always run; masked bytes are protected only by `ub_n`/`lb_n`=1.

## Test plan
- **Reset:** apply reset → all strobes 1, `dq_oe`=0, `mem_valid`=0, `wr_overflow`=0, `mem_busy`=0.
- **Read, W=2:** model holds hw 0x0008=0xBEEF and 0x0009=0xDEAD; read at `mem_addr` 0x10 → `sram_addr` 0x0008 for 3 cycles, then 0x0009 for 3 cycles; `mem_valid` 7 cycles after the first enable, with `mem_data`=0xDEADBEEF.
- **Partial write:** write 0x12345678, mask 4'b0011, `mem_addr` 0x20.
  - With SKIP_EN: hw 0x0010=0x5678 and `ce_n` low for exactly 4 cycles; hw 0x0011 unchanged.
  - Without SKIP_EN: a second phase runs with `ub_n`=`lb_n`=1.
- **Write then read same address:** write 0xCAFEF00D to 0x40, read 0x40 two cycles later → read waits for the FIFO to drain and returns 0xCAFEF00D.
- **Overflow:** three write pulses while a read is in progress, `WBUF_DEPTH`=2 → first two are written in order, third is dropped, `wr_overflow`=1 until reset.
- **Reset mid-read:** assert reset during RD_HI → strobes immediately 1; after release, no `mem_valid` and state IDLE.
